ff_reg_arbiter: RTL

- Round-robin arbiter plus a shared N-bit register (posedge D-register, write-enabled) owned by the block.
- REQ requesters compete for write access to the register.
- Grants are registered and one-hot; a requester may lock the grant for a bounded burst.
- Sits between multiple producers and a single shared state register, e.g. a shared status or config word.

---
 rtl/ff_reg_arbiter_if.sv | 20 ++
 rtl/ff_reg_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/ff_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: requests, lock, write data,
// plus the grant/owner/register view returned to the producers.
interface ff_reg_arbiter_if #(
  parameter int REQ = 4,
  parameter int N   = 8
);
  localparam int OW = (REQ > 1) ? $clog2(REQ) : 1;

  logic [REQ-1:0]   req;
  logic [REQ-1:0]   lock;
  logic [REQ*N-1:0] din;
  logic [REQ-1:0]   gnt;
  logic [OW-1:0]    owner;
  logic [N-1:0]     Q;
  logic             wr_done;
  logic             busy;

  modport master (output req, lock, din, input gnt, owner, Q, wr_done, busy);
  modport slave  (input req, lock, din, output gnt, owner, Q, wr_done, busy);
endinterface

// File: rtl/ff_reg_arbiter.sv
// Round-robin arbiter owning a shared N-bit register; the registered grant holder
// writes its din slice each granted cycle and may lock the grant for up to HOLD_MAX cycles.
module ff_reg_arbiter #(
  parameter int REQ      = 4,
  parameter int N        = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             res,
  ff_reg_arbiter_if.slave  bus
);
  localparam int OW = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   q_q, q_d;
  logic           wr_q, wr_d;

  logic [N-1:0]   owner_din;
  logic [OW-1:0]  cand;
  logic [OW-1:0]  winner;
  logic           found;
  logic           do_write;
  logic           stay;

  always_comb begin
    owner_din = '0;
    for (int i = 0; i < REQ; i++) begin
      if (owner_q == OW'(i)) owner_din = bus.din[i*N +: N];
    end
  end

  // Search starts just past the current owner and ends on the owner itself,
  // so a sole requester is re-granted but never ahead of anyone else.
  always_comb begin
    found  = 1'b0;
    winner = owner_q;
    cand   = owner_q;
    for (int k = 1; k <= REQ; k++) begin
      cand = OW'((int'(owner_q) + k) % REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign do_write = (state_q == GRANT) && bus.req[owner_q];
  assign stay     = do_write && bus.lock[owner_q] && (hold_q < HW'(HOLD_MAX));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    q_d     = q_q;
    wr_d    = 1'b0;

    if (do_write) begin
      q_d  = owner_din;
      wr_d = 1'b1;
    end

    if (stay) begin
      hold_d = hold_q + 1'b1;
    end else if (found) begin
      state_d = GRANT;
      gnt_d   = {{(REQ-1){1'b0}}, 1'b1} << winner;
      owner_d = winner;
      hold_d  = HW'(1);
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= OW'(REQ - 1);
      hold_q  <= '0;
      q_q     <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.Q       = q_q;
  assign bus.wr_done = wr_q;
  assign bus.busy    = |gnt_q;
endmodule
